// File: rtl/dot_product_stream_driver.sv
// dot_product_stream_driver
//   Feeds the 3-element serial dot-product engine. An A/B vector pair is
//   accepted over a valid/ready handshake, held in a one-deep pending slot,
//   then sent on din_o in the engine's 6-slot frame (A0 A1 A2 B0 B1 B2).
//   The engine's result is captured when it pulses run at the start of the
//   following frame, and is returned through a small result FIFO.
//
// Ports
//   clk, resetn            shared with the engine; resetn is synchronous, active-low
//   in_valid/in_ready      vector pair handshake; in_a/in_b element i at [W*i +: W]
//   din_o                  serial element stream to the engine
//   run_i, dout_i          engine run pulse and result
//   res_valid/res_ready    result handshake; res_data is the FIFO head
//   err_sync               sticky frame-alignment error
module dot_product_stream_driver #(
    parameter int W       = 8,
    parameter int RW      = 18,
    parameter int MAX_OUT = 2
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3*W-1:0]  in_a,
    input  logic [3*W-1:0]  in_b,
    output logic [W-1:0]    din_o,
    input  logic            run_i,
    input  logic [RW-1:0]   dout_i,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [RW-1:0]   res_data,
    output logic            err_sync
);

    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    // alive_q holds the slot counter at 0 for the first cycle after reset,
    // so that cycle is slot 0, matching the engine.
    logic            alive_q;
    logic [2:0]      s_q, s_d;
    logic            ready_q, ready_d;
    logic            pend_q, pend_d;
    logic [3*W-1:0]  pa_q, pa_d, pb_q, pb_d;
    logic [5*W-1:0]  sh_q, sh_d;       // remaining frame elements, next one in the low word
    logic [W-1:0]    din_q, din_d;
    logic            act_q, act_d;     // current cycle belongs to an active frame
    logic            tag_q, tag_d;     // active frame just finished; result due this s==0
    logic            err_q, err_d;
    logic [CW-1:0]   cred_q, cred_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [RW-1:0]   fifo_q [MAX_OUT];

    logic            hs, pop, push, go, cap;
    logic [RW-1:0]   push_val;
    logic [3*W-1:0]  va, vb;

    assign hs  = in_valid & ready_q;
    assign pop = (cnt_q != '0) & res_ready;

    always_comb begin
        s_d      = '0;
        go       = 1'b0;
        va       = pend_q ? pa_q : in_a;
        vb       = pend_q ? pb_q : in_b;
        din_d    = sh_q[W-1:0];
        sh_d     = sh_q >> W;
        act_d    = act_q;
        pend_d   = pend_q;
        pa_d     = pa_q;
        pb_d     = pb_q;
        tag_d    = tag_q;
        cap      = 1'b0;
        push     = 1'b0;
        push_val = '0;
        err_d    = err_q;
        cred_d   = cred_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        ready_d  = 1'b0;

        if (alive_q)
            s_d = (s_q == 3'd5) ? 3'd0 : s_q + 3'd1;

        // A frame starts on the next slot 0 if a pair is pending or is being
        // accepted right now (acceptance strictly precedes the frame start).
        if (s_d == 3'd0) begin
            go    = pend_q | hs;
            act_d = go;
        end
        if (go) begin
            din_d = va[W-1:0];
            sh_d  = {vb, va[3*W-1:W]};
        end

        if (go)
            pend_d = 1'b0;
        else if (hs) begin
            pend_d = 1'b1;
            pa_d   = in_a;
            pb_d   = in_b;
        end

        if (s_q == 3'd5 && act_q)
            tag_d = 1'b1;
        else if (s_q == 3'd0)
            tag_d = 1'b0;

        // A missing run still pushes (a zero) so credits stay balanced.
        cap      = (s_q == 3'd0) & tag_q;
        push     = cap;
        push_val = run_i ? dout_i : '0;
        err_d    = err_q | (run_i & (s_q != 3'd0)) | (cap & ~run_i);

        cred_d = cred_q + CW'(hs) - CW'(pop);
        cnt_d  = cnt_q + CW'(push) - CW'(pop);
        if (push)
            wr_d = (wr_q == PW'(MAX_OUT - 1)) ? '0 : wr_q + PW'(1);
        if (pop)
            rd_d = (rd_q == PW'(MAX_OUT - 1)) ? '0 : rd_q + PW'(1);

        ready_d = ~pend_d & (cred_d < CW'(MAX_OUT));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            alive_q <= 1'b0;
            s_q     <= '0;
            ready_q <= 1'b0;
            pend_q  <= 1'b0;
            pa_q    <= '0;
            pb_q    <= '0;
            sh_q    <= '0;
            din_q   <= '0;
            act_q   <= 1'b0;
            tag_q   <= 1'b0;
            err_q   <= 1'b0;
            cred_q  <= '0;
            cnt_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            for (int i = 0; i < MAX_OUT; i++)
                fifo_q[i] <= '0;
        end else begin
            alive_q <= 1'b1;
            s_q     <= s_d;
            ready_q <= ready_d;
            pend_q  <= pend_d;
            pa_q    <= pa_d;
            pb_q    <= pb_d;
            sh_q    <= sh_d;
            din_q   <= din_d;
            act_q   <= act_d;
            tag_q   <= tag_d;
            err_q   <= err_d;
            cred_q  <= cred_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            if (push)
                fifo_q[wr_q] <= push_val;
        end
    end

    assign in_ready  = ready_q;
    assign din_o     = din_q;
    assign err_sync  = err_q;
    assign res_valid = (cnt_q != '0);
    assign res_data  = (cnt_q != '0) ? fifo_q[rd_q] : '0;

endmodule

// File: tb/tb_dot_product_stream_driver.sv
module tb_dot_product_stream_driver;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_a = '0;
    logic [23:0] in_b = '0;
    logic [7:0]  din_o;
    logic        run_i = 1'b0;
    logic [17:0] dout_i = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [17:0] res_data;
    logic        err_sync;

    dot_product_stream_driver #(.W(8), .RW(18), .MAX_OUT(2)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .din_o(din_o), .run_i(run_i), .dout_i(dout_i),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .err_sync(err_sync)
    );

    always #5 clk = ~clk;

    int main_cmp = 0, main_bad = 0;
    int mon_cmp = 0, mon_bad = 0;
    int pops = 0;
    int cyc = -1;
    bit exp_zero = 0;
    bit inj_run2 = 0, inj_norun = 0;
    logic [17:0] exp_q[$];

    function automatic logic [17:0] model(input logic [23:0] a, input logic [23:0] b);
        int t = 0;
        for (int i = 0; i < 3; i++)
            t += int'(a[8*i +: 8]) * int'(b[8*i +: 8]);
        return 18'(t);
    endfunction

    always @(posedge clk) begin
        if (!resetn) cyc = -1;
        else cyc = cyc + 1;
    end

    // Engine model: slot counter leaving reset with the driver, collects six
    // din values per frame and presents their dot product with run at slot 0.
    int es = 0;
    bit ealive = 0, rs;
    logic [7:0] ebuf [6];
    always begin
        @(posedge clk);
        rs = resetn;
        if (!rs) begin
            es = 0;
            ealive = 0;
        end else begin
            if (ealive) es = (es == 5) ? 0 : es + 1;
            ealive = 1;
        end
        #1;
        if (!rs)
            for (int i = 0; i < 6; i++) ebuf[i] = '0;
        if (es == 0)
            dout_i = 18'(int'(ebuf[0]) * int'(ebuf[3]) + int'(ebuf[1]) * int'(ebuf[4])
                         + int'(ebuf[2]) * int'(ebuf[5]));
        ebuf[es] = din_o;
        run_i = (es == 0 && !inj_norun) || (es == 2 && inj_run2);
    end

    // Scoreboard monitor
    bit stall = 0;
    logic [17:0] hold = '0;
    logic [17:0] e;
    always @(negedge clk) begin
        if (!resetn) begin
            exp_q.delete();
            stall = 0;
        end else begin
            if (stall) begin
                mon_cmp++;
                if (!res_valid || res_data !== hold) begin
                    mon_bad++;
                    $display("FAIL hold_stable: got valid=%0b data=%0d, want valid=1 data=%0d",
                             res_valid, res_data, hold);
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(exp_zero ? 18'd0 : model(in_a, in_b));
            if (res_valid && res_ready) begin
                mon_cmp++;
                pops++;
                if (exp_q.size() == 0) begin
                    mon_bad++;
                    $display("FAIL result_unexpected: got %0d, want no result", res_data);
                end else begin
                    e = exp_q.pop_front();
                    if (res_data !== e) begin
                        mon_bad++;
                        $display("FAIL result: got %0d, want %0d", res_data, e);
                    end
                end
            end
            stall = res_valid && !res_ready;
            hold  = res_data;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        main_cmp++;
        if (act !== exp) begin
            main_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string nm);
        chk({nm, "_in_ready"}, 32'(in_ready), 0);
        chk({nm, "_din"}, 32'(din_o), 0);
        chk({nm, "_res_valid"}, 32'(res_valid), 0);
        chk({nm, "_res_data"}, 32'(res_data), 0);
        chk({nm, "_err"}, 32'(err_sync), 0);
    endtask

    // Ends just after the first edge that sees resetn high: cycle 0, slot 0.
    task automatic do_reset();
        @(posedge clk); #1;
        resetn = 0; in_valid = 0;
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk); #1;
        resetn = 1;
        @(posedge clk); #1;
    endtask

    // Called just after a rising edge; returns just after the handshake edge.
    task automatic offer(input logic [23:0] a, input logic [23:0] b, input string nm);
        bit got = 0;
        in_a = a; in_b = b; in_valid = 1;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            if (in_ready) got = 1;
            @(posedge clk); #1;
        end
        in_valid = 0;
        chk({nm, "_accepted"}, 32'(got), 1);
    endtask

    task automatic drain(input string nm);
        bit done = 0;
        in_valid = 0; res_ready = 1;
        for (int n = 0; n < 80 && !done; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !res_valid) done = 1;
            @(posedge clk); #1;
        end
        chk({nm, "_drained"}, 32'(done), 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        int bad_din, pb, nb;
        bit got;
        logic [7:0] r;
        logic [23:0] ra, rb;

        // Directed: (1,2,3).(4,5,6)=32, exact frame timing
        res_ready = 1;
        do_reset();
        in_a = {8'd3, 8'd2, 8'd1}; in_b = {8'd6, 8'd5, 8'd4}; in_valid = 1;
        @(negedge clk);
        chk("in_ready_cycle0", 32'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 0;
        @(negedge clk);
        chk("in_ready_pending", 32'(in_ready), 0);
        bad_din = 0;
        while (cyc < 14) begin
            if (cyc >= 6 && cyc <= 11) chk("din_frame", 32'(din_o), 32'(cyc - 5));
            else if (cyc < 6 && din_o != 0) bad_din++;
            if (cyc == 12) chk("res_valid_c12", 32'(res_valid), 0);
            if (cyc == 13) begin
                chk("res_valid_c13", 32'(res_valid), 1);
                chk("res_data_c13", 32'(res_data), 32);
            end
            @(negedge clk);
        end
        chk("din_idle_pre", 32'(bad_din), 0);
        @(posedge clk); #1;

        // Maximum operands
        offer({3{8'd255}}, {3{8'd255}}, "max");
        drain("max");
        @(negedge clk);
        chk("max_err", 32'(err_sync), 0);
        @(posedge clk); #1;

        // Backpressure: two accepted, third waits for a pop
        do_reset();
        res_ready = 0;
        offer({8'd1, 8'd1, 8'd1}, {8'd7, 8'd8, 8'd9}, "bp1");
        offer({8'd2, 8'd0, 8'd5}, {8'd3, 8'd4, 8'd6}, "bp2");
        in_a = {8'd9, 8'd9, 8'd9}; in_b = {8'd1, 8'd2, 8'd3}; in_valid = 1;
        nb = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (in_ready) nb++;
        end
        chk("bp_third_blocked", 32'(nb), 0);
        chk("bp_res_valid", 32'(res_valid), 1);
        @(posedge clk); #1;
        pb = pops;
        res_ready = 1;
        offer({8'd9, 8'd9, 8'd9}, {8'd1, 8'd2, 8'd3}, "bp3");
        chk("bp_pop_before_third", 32'(pops > pb), 1);
        drain("bp");

        // Idle period
        nb = 0; bad_din = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (din_o != 0) bad_din++;
            if (res_valid || err_sync) nb++;
        end
        chk("idle_din", 32'(bad_din), 0);
        chk("idle_valid_err", 32'(nb), 0);
        @(posedge clk); #1;

        // Stray run at slot 2
        inj_run2 = 1;
        repeat (7) @(posedge clk);
        #1 inj_run2 = 0;
        @(negedge clk);
        chk("err_run_s2", 32'(err_sync), 1);
        repeat (10) @(negedge clk);
        chk("err_sticky", 32'(err_sync), 1);
        @(posedge clk); #1;
        do_reset();

        // Missing run at capture slot: result lost, zero pushed
        exp_zero = 1; inj_norun = 1;
        offer({8'd10, 8'd20, 8'd30}, {8'd1, 8'd1, 8'd1}, "norun");
        drain("norun");
        inj_norun = 0; exp_zero = 0;
        @(negedge clk);
        chk("err_norun", 32'(err_sync), 1);
        @(posedge clk); #1;

        // Reset at slot 3 of an active frame
        do_reset();
        offer({8'd3, 8'd2, 8'd1}, {8'd6, 8'd5, 8'd4}, "mid");
        got = 0;
        for (int n = 0; n < 30 && !got; n++) begin
            if (es == 3 && din_o == 8'd4) got = 1;
            else begin @(posedge clk); #1; end
        end
        chk("mid_reached_s3", 32'(got), 1);
        resetn = 0;
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("mid_reset");
        @(posedge clk); #1;
        resetn = 1;
        @(posedge clk); #1;
        offer({8'd1, 8'd0, 8'd2}, {8'd4, 8'd9, 8'd3}, "post");
        got = 0;
        for (int n = 0; n < 30 && !got; n++) begin
            @(negedge clk);
            if (res_valid) begin
                got = 1;
                chk("post_result", 32'(res_data), 10);
            end
        end
        chk("post_valid", 32'(got), 1);
        @(posedge clk); #1;
        drain("post");

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            in_valid = ($urandom % 3) != 0;
            for (int i = 0; i < 3; i++) begin
                r = 8'($urandom);
                ra[8*i +: 8] = (($urandom % 4) == 0) ? 8'd255 : r;
                rb[8*i +: 8] = (($urandom % 4) == 0) ? 8'd0 : 8'($urandom);
            end
            in_a = ra; in_b = rb;
            res_ready = ($urandom % 4) != 0;
            @(posedge clk); #1;
        end
        drain("rand");
        @(negedge clk);
        chk("rand_err", 32'(err_sync), 0);
        chk("rand_compared_any", 32'(mon_cmp > 20), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 main_cmp + mon_cmp, main_bad + mon_bad);
        $finish;
    end

endmodule
